// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding Wishbone reads and feeds the decoder.
// Optional build macro FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into fetch faults.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_adr_o,
    output logic        imem_cyc_o,
    output logic        imem_stb_o,
    input  logic [31:0] imem_dat_i,
    input  logic        imem_ack_i,
    input  logic        imem_err_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        fetch_err_o
);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, KILL, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] adr_q, adr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pco_q, pco_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        skid_valid_q, skid_valid_d;
    logic        skid_err_q, skid_err_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        consume;
    logic        slot_free;
    logic [31:0] redir_pc;
    logic        redir_trap;

    assign consume   = valid_q & ~stall_i;
    assign slot_free = ~valid_q | ~stall_i;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_pc   = redirect_pc_i;
    assign redir_trap = |redirect_pc_i[1:0];
`else
    assign redir_pc   = redirect_pc_i & ~32'h3;
    assign redir_trap = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        adr_d        = adr_q;
        cyc_d        = cyc_q;
        instr_d      = instr_q;
        pco_d        = pco_q;
        valid_d      = valid_q;
        ferr_d       = ferr_q;
        skid_valid_d = skid_valid_q;
        skid_err_d   = skid_err_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (redirect_i) begin
            valid_d      = 1'b0;
            ferr_d       = 1'b0;
            instr_d      = NOP_INSTR;
            skid_valid_d = 1'b0;
            skid_err_d   = 1'b0;
            pc_d         = redir_pc;
            if (redir_trap) begin
                valid_d = 1'b1;
                ferr_d  = 1'b1;
                pco_d   = redirect_pc_i;
                cyc_d   = 1'b0;
                state_d = HALT;
            end else if (cyc_q && !(imem_ack_i || imem_err_i)) begin
                // The old read is still owed a response; keep the cycle open and swallow it.
                state_d = KILL;
            end else begin
                state_d = REQ;
                cyc_d   = 1'b1;
                adr_d   = redir_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    adr_d   = pc_q;
                end
                REQ: begin
                    if (imem_err_i) begin
                        cyc_d   = 1'b0;
                        state_d = HALT;
                        if (slot_free) begin
                            valid_d = 1'b1;
                            ferr_d  = 1'b1;
                            instr_d = NOP_INSTR;
                            pco_d   = adr_q;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_err_d   = 1'b1;
                            skid_instr_d = NOP_INSTR;
                            skid_pc_d    = adr_q;
                            state_d      = HOLD;
                        end
                    end else if (imem_ack_i) begin
                        pc_d = pc_q + 32'd4;
                        if (slot_free) begin
                            valid_d = 1'b1;
                            ferr_d  = 1'b0;
                            instr_d = imem_dat_i;
                            pco_d   = adr_q;
                            adr_d   = pc_q + 32'd4;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_err_d   = 1'b0;
                            skid_instr_d = imem_dat_i;
                            skid_pc_d    = adr_q;
                            cyc_d        = 1'b0;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i && skid_valid_q) begin
                        valid_d      = 1'b1;
                        ferr_d       = skid_err_q;
                        instr_d      = skid_instr_q;
                        pco_d        = skid_pc_q;
                        skid_valid_d = 1'b0;
                        skid_err_d   = 1'b0;
                        if (skid_err_q) begin
                            state_d = HALT;
                        end else begin
                            state_d = REQ;
                            cyc_d   = 1'b1;
                            adr_d   = pc_q;
                        end
                    end
                end
                KILL: begin
                    if (imem_ack_i || imem_err_i) begin
                        state_d = REQ;
                        cyc_d   = 1'b1;
                        adr_d   = pc_q;
                    end
                end
                HALT: begin
                    cyc_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_ADDR;
            adr_q        <= RESET_ADDR;
            cyc_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            pco_q        <= 32'h0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_err_q   <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            adr_q        <= adr_d;
            cyc_q        <= cyc_d;
            instr_q      <= instr_d;
            pco_q        <= pco_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            skid_valid_q <= skid_valid_d;
            skid_err_q   <= skid_err_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_adr_o    = adr_q;
    assign imem_cyc_o    = cyc_q;
    assign imem_stb_o    = cyc_q;
    assign instruction_o = instr_q;
    assign pc_o          = pco_q;
    assign valid_o       = valid_q;
    assign fetch_err_o   = ferr_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the program counter and issues one-outstanding Wishbone-classic reads to instruction memory.
- Presents instruction_o, pc_o and valid_o to the decoder, with backpressure through stall_i.
- Accepts redirects from jump/branch resolution and has a one-entry skid buffer, so an in-flight response is never lost under stall.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instruction_o when nothing is valid.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- imem_adr_o  out  32  fetch address (word aligned).
- imem_cyc_o  out  1  bus cycle active.
- imem_stb_o  out  1  strobe; equals imem_cyc_o.
- imem_dat_i  in  32  read data.
- imem_ack_i  in  1  read complete.
- imem_err_i  in  1  bus error; takes the place of ack.
- stall_i  in  1  decoder cannot accept this cycle.
- redirect_i  in  1  load new PC.
- redirect_pc_i  in  32  redirect target.
- instruction_o  out  32  fetched instruction.
- pc_o  out  32  address of instruction_o.
- valid_o  out  1  instruction_o/pc_o valid.
- fetch_err_o  out  1  qualifies valid_o: the fetch faulted.

Behaviour:
- All outputs registered.
- Reset values: imem_cyc_o=imem_stb_o=0, imem_adr_o=RESET_ADDR, instruction_o=NOP_INSTR, pc_o=0, valid_o=0, fetch_err_o=0, pc_q=RESET_ADDR, skid empty, state IDLE.
- Transfer rule: the decoder consumes the slot on any edge where valid_o=1 and stall_i=0.
- States are IDLE, REQ, HOLD, KILL, HALT.
- IDLE: on the first edge with rst_i=0, go to REQ; cyc/stb=1 and adr=pc_q.
- REQ: adr/cyc/stb stay stable until ack or err.
  - On ack, if the slot is free or being consumed: instruction_o=dat_i, pc_o=adr, valid_o=1, pc_q+=4. The next request goes out at the same edge (adr=pc_q+4), so a zero-wait slave sustains 1 instr/cycle.
  - On ack while valid_o=1 and stall_i=1: capture dat_i/adr into the skid, drop cyc/stb, go to HOLD.
- HOLD: when stall_i=0, move skid to output (valid_o=1), reissue a request at pc_q, go to REQ.
- Error: on imem_err_i, output valid_o=1, fetch_err_o=1, instruction_o=NOP_INSTR, pc_o=faulting adr. Drop cyc/stb and go to HALT. No further fetches until a redirect.
- Redirect (highest priority, any state):
  - At that edge: valid_o=0, fetch_err_o=0, skid emptied, pc_q=redirect_pc_i.
  - If a request is pending with no ack/err that cycle: go to KILL. cyc/stb stay high at the old address; the response is discarded. Then go to REQ at pc_q.
  - If ack/err coincides with the redirect: the data is discarded and state goes directly to REQ at redirect_pc_i.
  - A redirect while in KILL overwrites pc_q only.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- rst_i mid-transaction: return to reset values at that edge. cyc is dropped immediately; a late ack is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc_i[1:0]!=0 issues no bus request. On the next edge, output valid_o=1, fetch_err_o=1, pc_o=redirect_pc_i, instruction_o=NOP_INSTR, and go to HALT.
- Undefined: redirect_pc_i[1:0] is forced to 2'b00 and fetch proceeds normally.

Test Plan:
- Reset release, slave acks in the same cycle as stb, memory[i]=i → adr 0,4,8,… on consecutive cycles; valid_o=1 each cycle from the second edge; pc_o/instruction_o match.
- stall_i=1 for 3 cycles while a request is in flight and the slot holds pc 0x4 → the ack at 0x8 goes to the skid and cyc drops. After release, 0x4 then 0x8 are delivered in order, then the request at 0xC.
- Redirect to 0x100 while the request at 0x10 waits with 2-cycle ack latency → the 0x10 data is never presented; next adr=0x100; valid_o=0 until 0x100 is acked.
- Redirect to 0x200 coincident with ack → ack data dropped; adr=0x200 on the next cycle.
- imem_err_i at 0x40 → valid_o=1, fetch_err_o=1, pc_o=0x40, no further stb. A redirect to 0x0 resumes fetch.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → fetch_err_o=1 with pc_o=0x102 and no bus cycle. Without the macro → adr=0x100 fetched.
